// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the ASYNC_FIFO write port among NUM_REQ
// valid/ready producers, with bounded bursts and FULL backpressure.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned GNT_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         Wr_DATA,
  output logic [GNT_WIDTH-1:0]          GNT_ID,
  output logic                          BUSY,
  output logic [CNT_WIDTH-1:0]          WR_COUNT
);

  localparam int unsigned BEAT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(MAX_BURST - 1);
  localparam logic [GNT_WIDTH-1:0]  LAST_REQ  = GNT_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [GNT_WIDTH-1:0]  gnt_q, gnt_d;
  logic [GNT_WIDTH-1:0]  last_q, last_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic                  valid_gnt_c;
  logic                  transfer_c;
  logic [NUM_REQ-1:0]    rot_valid_c;
  logic [2*NUM_REQ-1:0]  dbl_valid_c;
  logic                  found_c;
  logic [GNT_WIDTH-1:0]  winner_c;

  // Granted producer's valid and data, selected by a plain mux.
  always_comb begin
    valid_gnt_c = 1'b0;
    Wr_DATA     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_q == GNT_WIDTH'(i)) begin
        valid_gnt_c = REQ_VALID[i];
        Wr_DATA     = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign transfer_c = (state_q == GRANT) && valid_gnt_c && !FULL;
  assign W_INC      = transfer_c;

  // Ready only toward the granted producer, and never while the FIFO is full.
  always_comb begin
    REQ_READY = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      REQ_READY[i] = (state_q == GRANT) && (gnt_q == GNT_WIDTH'(i)) && !FULL;
    end
  end

  // Rotate valids so bit 0 is the producer right after last_q; the lowest set bit wins.
  always_comb begin
    dbl_valid_c = {REQ_VALID, REQ_VALID};
    rot_valid_c = NUM_REQ'(dbl_valid_c >> (32'(last_q) + 32'd1));
    found_c     = 1'b0;
    winner_c    = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!found_c && rot_valid_c[j]) begin
        found_c  = 1'b1;
        winner_c = GNT_WIDTH'((32'(last_q) + 32'd1 + 32'(j)) % NUM_REQ);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d   = winner_c;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (transfer_c) begin
          beat_d = beat_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
        // A stalled final beat holds the grant; a dropped valid releases even under FULL.
        if ((transfer_c && (beat_q == LAST_BEAT)) || !valid_gnt_c) begin
          state_d = IDLE;
          last_d  = gnt_q;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_REQ;
      beat_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT_ID   = gnt_q;
  assign BUSY     = busy_q;
  assign WR_COUNT = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: scripted scenarios plus random
// traffic checked every cycle against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            CLK;
  logic            RST;
  logic [NR-1:0]   REQ_VALID;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]   REQ_READY;
  logic            FULL;
  logic            W_INC;
  logic [DW-1:0]   Wr_DATA;
  logic [1:0]      GNT_ID;
  logic            BUSY;
  logic [15:0]     WR_COUNT;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .FULL(FULL), .W_INC(W_INC), .Wr_DATA(Wr_DATA),
    .GNT_ID(GNT_ID), .BUSY(BUSY), .WR_COUNT(WR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Producer side: each producer sends p_left more words, value p_base + words already accepted.
  int         p_left[NR];
  int         p_seq[NR];
  logic [7:0] p_base[NR];
  logic       full_q;
  logic [7:0] wr_log[$];

  // Reference model: who owns the port, beats taken this grant, last owner, total writes.
  bit          m_grant;
  int          m_id;
  int          m_beats;
  int          m_last;
  logic [15:0] m_count;

  task automatic m_reset();
    m_grant = 0; m_id = 0; m_beats = 0; m_last = NR - 1; m_count = 16'd0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      REQ_VALID[i] = (p_left[i] > 0);
      REQ_DATA[i*DW +: DW] = p_base[i] + 8'(p_seq[i]);
    end
    FULL = full_q;
  endtask

  // One clock: drive at negedge, check 1ns later, let posedge happen, return at next negedge.
  task automatic tick();
    logic [NR-1:0] v, exp_ready;
    logic          exp_xfer;
    logic [7:0]    exp_data;
    drive_inputs();
    #1;
    v = REQ_VALID;
    if (!RST) begin
      m_reset();
      exp_xfer = 1'b0; exp_ready = '0;
    end else begin
      exp_xfer  = m_grant && v[m_id] && !full_q;
      exp_ready = (m_grant && !full_q) ? 4'(1 << m_id) : 4'b0;
    end
    exp_data = p_base[m_id] + 8'(p_seq[m_id]);
    checks++; if (W_INC !== exp_xfer) begin errors++; $display("FAIL w_inc t=%0t got %b exp %b", $time, W_INC, exp_xfer); end
    checks++; if (REQ_READY !== exp_ready) begin errors++; $display("FAIL req_ready t=%0t got %b exp %b", $time, REQ_READY, exp_ready); end
    checks++; if (BUSY !== m_grant) begin errors++; $display("FAIL busy t=%0t got %b exp %b", $time, BUSY, m_grant); end
    checks++; if (GNT_ID !== 2'(m_id)) begin errors++; $display("FAIL gnt_id t=%0t got %0d exp %0d", $time, GNT_ID, m_id); end
    checks++; if (WR_COUNT !== m_count) begin errors++; $display("FAIL wr_count t=%0t got %0d exp %0d", $time, WR_COUNT, m_count); end
    if (exp_xfer) begin
      checks++; if (Wr_DATA !== exp_data) begin errors++; $display("FAIL wr_data t=%0t got %h exp %h", $time, Wr_DATA, exp_data); end
    end
    if (W_INC === 1'b1) wr_log.push_back(Wr_DATA);
    for (int i = 0; i < NR; i++) begin
      if (REQ_VALID[i] && REQ_READY[i] === 1'b1) begin p_seq[i]++; p_left[i]--; end
    end
    if (RST) begin
      if (!m_grant) begin
        if (v != '0) begin
          for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_last + k) % NR;
            if (v[c]) begin m_id = c; break; end
          end
          m_grant = 1; m_beats = 0;
        end
      end else begin
        if (exp_xfer) begin m_beats++; m_count = m_count + 16'd1; end
        if ((exp_xfer && m_beats == MB) || !v[m_id]) begin
          m_grant = 0; m_last = m_id; m_beats = 0;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    full_q = 1'b0;
    for (int i = 0; i < NR; i++) begin p_left[i] = 0; p_seq[i] = 0; p_base[i] = 8'(16 * i); end
    tick();
    tick();
    RST = 1'b1;
    wr_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 10; n++) tick();
    drive_inputs(); #1;
    checks++; if (W_INC !== 1'b0) begin errors++; $display("FAIL reset_w_inc got %b exp 0", W_INC); end
    checks++; if (REQ_READY !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", REQ_READY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (GNT_ID !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d exp 0", GNT_ID); end
    checks++; if (WR_COUNT !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", WR_COUNT); end
  endtask

  task automatic test_single_producer();
    logic [7:0] exp_q[$];
    do_reset();
    p_base[2] = 8'hA0; p_left[2] = 6;
    for (int n = 0; n < 14; n++) tick();
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    checks++;
    if (wr_log.size() != exp_q.size()) begin errors++; $display("FAIL single_len got %0d exp %0d", wr_log.size(), exp_q.size()); end
    else foreach (exp_q[k]) if (wr_log[k] !== exp_q[k]) begin errors++; $display("FAIL single_word[%0d] got %h exp %h", k, wr_log[k], exp_q[k]); end
    drive_inputs(); #1;
    checks++; if (WR_COUNT !== 16'd6) begin errors++; $display("FAIL single_count got %0d exp 6", WR_COUNT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", BUSY); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    do_reset();
    p_left[0] = 8; p_left[1] = 4; p_left[2] = 4; p_left[3] = 4;
    for (int n = 0; n < 27; n++) tick();
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
              8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
              8'h04, 8'h05, 8'h06, 8'h07};
    checks++;
    if (wr_log.size() != exp_q.size()) begin errors++; $display("FAIL rr_len got %0d exp %0d", wr_log.size(), exp_q.size()); end
    else foreach (exp_q[k]) if (wr_log[k] !== exp_q[k]) begin errors++; $display("FAIL rr_word[%0d] got %h exp %h", k, wr_log[k], exp_q[k]); end
  endtask

  task automatic test_full_stall();
    logic [7:0] exp_q[$];
    do_reset();
    p_base[1] = 8'h50; p_left[1] = 4;
    for (int n = 0; n < 20 && p_seq[1] < 2; n++) tick();
    checks++; if (p_seq[1] != 2) begin errors++; $display("FAIL stall_prefix got %0d beats exp 2", p_seq[1]); end
    full_q = 1'b1;
    for (int n = 0; n < 5; n++) begin
      drive_inputs(); #1;
      checks++; if (W_INC !== 1'b0 || REQ_READY[1] !== 1'b0 || GNT_ID !== 2'd1)
        begin errors++; $display("FAIL stall_hold w_inc=%b ready1=%b gnt=%0d exp 0 0 1", W_INC, REQ_READY[1], GNT_ID); end
      tick();
    end
    full_q = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    checks++;
    if (wr_log.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", wr_log.size(), exp_q.size()); end
    else foreach (exp_q[k]) if (wr_log[k] !== exp_q[k]) begin errors++; $display("FAIL stall_word[%0d] got %h exp %h", k, wr_log[k], exp_q[k]); end
  endtask

  task automatic test_early_release();
    logic [7:0] exp_q[$];
    do_reset();
    p_left[0] = 2; p_left[3] = 3;
    for (int n = 0; n < 20 && p_seq[0] < 2; n++) tick();
    tick();
    drive_inputs(); #1;
    checks++; if (WR_COUNT !== 16'd2) begin errors++; $display("FAIL early_count got %0d exp 2", WR_COUNT); end
    for (int n = 0; n < 8; n++) tick();
    exp_q = '{8'h00, 8'h01, 8'h30, 8'h31, 8'h32};
    checks++;
    if (wr_log.size() != exp_q.size()) begin errors++; $display("FAIL early_len got %0d exp %0d", wr_log.size(), exp_q.size()); end
    else foreach (exp_q[k]) if (wr_log[k] !== exp_q[k]) begin errors++; $display("FAIL early_word[%0d] got %h exp %h", k, wr_log[k], exp_q[k]); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < NR; i++) p_left[i] = 8;
    for (int n = 0; n < 60 && !(m_grant && m_id == 2 && m_beats == 1); n++) tick();
    checks++; if (!(m_grant && m_id == 2 && m_beats == 1)) begin errors++; $display("FAIL midrst_reach got id=%0d beats=%0d exp id=2 beats=1", m_id, m_beats); end
    drive_inputs(); #1;
    checks++; if (W_INC !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", W_INC); end
    RST = 1'b0;
    #1;
    checks++; if (W_INC !== 1'b0 || REQ_READY !== 4'b0000 || BUSY !== 1'b0 || WR_COUNT !== 16'd0)
      begin errors++; $display("FAIL midrst_async w_inc=%b ready=%b busy=%b count=%0d exp 0 0000 0 0", W_INC, REQ_READY, BUSY, WR_COUNT); end
    m_reset();
    @(negedge CLK);
    tick();
    tick();
    RST = 1'b1;
    wr_log.delete();
    tick();
    drive_inputs(); #1;
    checks++; if (GNT_ID !== 2'd0 || W_INC !== 1'b1 || WR_COUNT !== 16'd0)
      begin errors++; $display("FAIL midrst_regrant gnt=%0d w_inc=%b count=%0d exp 0 1 0", GNT_ID, W_INC, WR_COUNT); end
    for (int n = 0; n < 6; n++) tick();
  endtask

  task automatic test_random();
    int total;
    do_reset();
    for (int i = 0; i < NR; i++) p_base[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (p_left[i] == 0 && $urandom_range(0, 3) == 0) p_left[i] = $urandom_range(1, 7);
        else if (p_left[i] > 0 && $urandom_range(0, 19) == 0) p_left[i] = 0;
      end
      full_q = ($urandom_range(0, 4) == 0);
      tick();
    end
    for (int i = 0; i < NR; i++) p_left[i] = 0;
    full_q = 1'b0;
    tick(); tick(); tick();
    total = 0;
    for (int i = 0; i < NR; i++) total += p_seq[i];
    checks++; if (wr_log.size() != total) begin errors++; $display("FAIL rand_accepts got %0d writes exp %0d", wr_log.size(), total); end
    drive_inputs(); #1;
    checks++; if (WR_COUNT !== 16'(total)) begin errors++; $display("FAIL rand_count got %0d exp %0d", WR_COUNT, total); end
  endtask

  initial begin
    RST = 1'b0; FULL = 1'b0; REQ_VALID = '0; REQ_DATA = '0;
    m_reset();
    test_reset();
    test_single_producer();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
